uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of UART transmitter requesters; index 0 = mode notifier, 1 = SHOW transmitter, 2 = spare/CALC.
REQ-002 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency.
REQ-003 SHALL have parameter BAUD_RATE, default 115200; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer truncation).
REQ-004 SHALL have parameter GAP_BITS, default 2, idle-line guard between owners, in bit times.
REQ-005 SHALL have parameter START_TIMEOUT, default 1024, clock cycles a grantee may hold the line without raising busy.
REQ-006 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 req  input  NUM_REQ  per-requester line request, level, held until its transfer is done.
REQ-009 busy_in  input  NUM_REQ  per-requester transmitter busy.
REQ-010 tx_in  input  NUM_REQ  per-requester serial output.
REQ-011 grant  output  NUM_REQ  registered one-hot ownership; all zero when no owner.
REQ-012 owner_id  output  2  index of current/last owner.
REQ-013 uart_tx  output  1  shared serial line.
REQ-014 line_busy  output  1  high in any state except IDLE.
REQ-015 timeout_err  output  1  one-cycle pulse on start timeout.

Function
REQ-016 SHALL implement states IDLE, GRANT, ACTIVE, GAP.
REQ-017 IDLE: uart_tx=1, grant=0; if any req bit high at edge t, winner's grant bit SHALL be 1 at t+1, state GRANT, owner_id=winner.
REQ-018 Winner: lowest index with req high (fixed priority) unless REQ-031 applies.
REQ-019 GRANT: uart_tx=tx_in[owner]; busy_in[owner]=1 -> ACTIVE; req[owner]=0 with busy_in[owner]=0 -> GAP; timeout counter reaches START_TIMEOUT -> GAP and timeout_err pulse.
REQ-020 ACTIVE: uart_tx=tx_in[owner]; busy_in[owner]=0 and req[owner]=1 -> GRANT (burst, timeout counter cleared); busy_in[owner]=0 and req[owner]=0 -> GAP.
REQ-021 GAP: grant=0, uart_tx=1 for exactly GAP_BITS*CLKS_PER_BIT cycles, then IDLE; arbitration occurs in IDLE on the following edge.
REQ-022 uart_tx SHALL be driven combinationally from owner's tx_in in GRANT/ACTIVE (zero added latency); tx_in of non-owners ignored.
REQ-023 req of non-owners SHALL never preempt; requests are sampled only in IDLE.
REQ-024 busy_in of a non-owner SHALL be ignored.
REQ-025 Simultaneous requests in IDLE: exactly one grant bit set; others wait.
REQ-026 Timeout counter width SHALL be ceil(log2(START_TIMEOUT+1)); gap counter width ceil(log2(GAP_BITS*CLKS_PER_BIT+1)); neither wraps.

Reset
REQ-027 On rst_n low, immediately and regardless of state: state=IDLE, grant=0, owner_id=0, uart_tx=1, line_busy=0, timeout_err=0, counters=0.
REQ-028 Reset mid-frame SHALL force uart_tx=1 asynchronously; no frame resumes after release.
REQ-029 First arbitration SHALL occur on the first rising edge after rst_n deasserts with req nonzero.

Configuration
REQ-030 Macro UART_ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-031 Defined: winner is first requester with req high searching from (last owner_id+1) mod NUM_REQ upward, wrapping; last owner_id after reset = NUM_REQ-1 so index 0 wins first.
REQ-032 Undefined: fixed priority per REQ-018; no round-robin pointer logic compiled.

Verification (CLK_FREQ_HZ=1000, BAUD_RATE=100, GAP_BITS=2, START_TIMEOUT=16, NUM_REQ=3)
REQ-033 req=3'b110 in IDLE -> grant=3'b010 next cycle, owner_id=1; busy_in[1] high 30 cycles then req[1] drop -> GAP 20 cycles uart_tx=1, then grant=3'b100.
REQ-034 Owner 0 granted, tx_in[0] toggling, tx_in[1]=0 -> uart_tx tracks tx_in[0] cycle-exact, never 0 from tx_in[1].
REQ-035 Grant to 2, busy_in[2] never rises -> after 16 cycles timeout_err one pulse, GAP, grant=0.
REQ-036 rst_n low mid-ACTIVE with tx_in[owner]=0 -> uart_tx=1, grant=0 same cycle; after release with req=0 stays IDLE.
REQ-037 ROUND_ROBIN_EN defined, req=3'b111 held, each owner one 10-cycle busy burst -> grant order 0,1,2,0; undefined -> order 0,0,0.
REQ-038 Owner 1 busy drops with req[1] still high -> returns to GRANT, no gap, grant stays 3'b010; second busy burst accepted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX line between NUM_REQ transmitters with a guard gap between owners.
// Build option: define UART_ARB_ROUND_ROBIN_EN for round-robin arbitration (default fixed priority).
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int CLK_FREQ_HZ   = 100_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int GAP_BITS      = 2,
    parameter int START_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] busy_in,
    input  logic [NUM_REQ-1:0] tx_in,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         owner_id,
    output logic               uart_tx,
    output logic               line_busy,
    output logic               timeout_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int GAP_CYCLES   = GAP_BITS * CLKS_PER_BIT;
    localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TO_W         = (START_TIMEOUT > 0) ? $clog2(START_TIMEOUT + 1) : 1;
    localparam int GAP_W        = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(START_TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_owner;
    logic [1:0]         w_owner_nxt;
    logic [1:0]         w_win;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic               r_timeout_err;
    logic               w_timeout;
    logic [TO_W-1:0]    r_to_cnt;
    logic [TO_W-1:0]    w_to_nxt;
    logic [TO_W-1:0]    w_to_inc;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [GAP_W-1:0]   w_gap_nxt;
    logic               w_own_req;
    logic               w_own_busy;
    logic               w_own_tx;
    logic               w_owns_line;

    // Only the owner's request/busy/serial bits are ever looked at.
    assign w_owner_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_own_req   = |(req & w_owner_oh);
    assign w_own_busy  = |(busy_in & w_owner_oh);
    assign w_own_tx    = |(tx_in & w_owner_oh);
    assign w_owns_line = (r_state == ST_GRANT) || (r_state == ST_ACTIVE);
    assign w_to_inc    = r_to_cnt + TO_W'(1);

`ifdef UART_ARB_ROUND_ROBIN_EN
    logic [1:0] r_rr_last;

    // Round-robin winner: nearest requester after the last owner (nearest offset assigned last).
    always_comb begin
        w_win = 2'd0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_win = req[IDX_W'((int'(r_rr_last) + k) % NUM_REQ)] ?
                    2'((int'(r_rr_last) + k) % NUM_REQ) : w_win;
        end
    end

    // Round-robin pointer; starts at the top index so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= 2'(NUM_REQ - 1);
        end else if ((r_state == ST_IDLE) && (|req)) begin
            r_rr_last <= w_win;
        end else begin
            r_rr_last <= r_rr_last;
        end
    end
`else
    // Fixed priority winner: lowest index with a request.
    always_comb begin
        w_win = 2'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_win = req[IDX_W'(i)] ? 2'(i) : w_win;
        end
    end
`endif

    // Next-state, counter and grant decode.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_timeout   = 1'b0;
        w_to_nxt    = {TO_W{1'b0}};
        w_gap_nxt   = {GAP_W{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = ST_GRANT;
                    w_owner_nxt = w_win;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (w_own_busy) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (!w_own_req) begin
                    w_state_nxt = ST_GAP;
                end else if (w_to_inc == TO_LIMIT) begin
                    w_state_nxt = ST_GAP;
                    w_timeout   = 1'b1;
                end else begin
                    w_to_nxt = w_to_inc;
                end
            end
            ST_ACTIVE: begin
                if (w_own_busy) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (w_own_req) begin
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if ((w_state_nxt == ST_GRANT) || (w_state_nxt == ST_ACTIVE)) begin
            w_grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_owner_nxt;
        end else begin
            w_grant_nxt = {NUM_REQ{1'b0}};
        end
    end

    // State, owner, grant, pulse and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_owner       <= 2'd0;
            r_grant       <= {NUM_REQ{1'b0}};
            r_timeout_err <= 1'b0;
            r_to_cnt      <= {TO_W{1'b0}};
            r_gap_cnt     <= {GAP_W{1'b0}};
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_grant       <= w_grant_nxt;
            r_timeout_err <= w_timeout;
            r_to_cnt      <= w_to_nxt;
            r_gap_cnt     <= w_gap_nxt;
        end
    end

    // The line idles high whenever nobody owns it, including during reset.
    assign uart_tx     = w_owns_line ? w_own_tx : 1'b1;
    assign grant       = r_grant;
    assign owner_id    = r_owner;
    assign line_busy   = (r_state != ST_IDLE);
    assign timeout_err = r_timeout_err;

endmodule
